// File: rtl/comp_capture.sv
// Captures NBITS synchronised comparator decisions per conversion, MSB first, tagged with mux_sel.
// Latency: last bit_strobe at T -> PUSH at T+SYNC_STAGES+1 -> word_valid at T+SYNC_STAGES+2 (empty FIFO).
// Backpressure: FWFT FIFO holds words while word_ready=0; a word completing into a full FIFO with no pop is dropped and flagged.
module comp_capture #(
    parameter int NBITS       = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             comp_out,
    input  logic [3:0]       mux_sel,
    input  logic             conv_start,
    input  logic             bit_strobe,
    output logic [NBITS-1:0] word_data,
    output logic [3:0]       word_sel,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overflow,
    input  logic             ovf_clr,
    inout  wire              vdd_d,
    inout  wire              vss_d
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = NBITS + 4;
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PUSH    = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Supply pins carry no logic; they are only tied off here.
    wire supply_unused = vdd_d ^ vss_d;

    logic [SYNC_STAGES-1:0] comp_sync;
    logic [SYNC_STAGES-1:0] strb_sync;
    logic                   comp_s;
    logic                   strb_a;

    logic [NBITS-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       sel_q;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fcnt;
    logic [EW-1:0] head;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          drop;

    // Synchronise comp_out and delay bit_strobe by the same depth so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_sync <= '0;
            strb_sync <= '0;
        end else begin
            comp_sync <= {comp_sync[SYNC_STAGES-2:0], comp_out};
            strb_sync <= {strb_sync[SYNC_STAGES-2:0], bit_strobe};
        end
    end

    assign comp_s = comp_sync[SYNC_STAGES-1];
    assign strb_a = strb_sync[SYNC_STAGES-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a mux_sel change during capture aborts the word before any strobe is considered.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (conv_start) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (mux_sel != sel_q) begin
                    state_nxt = IDLE;
                end else if (strb_a && (bit_cnt == LAST_BIT)) begin
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture datapath: clear and latch selection on start, shift one decision per aligned strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            sel_q     <= '0;
        end else if ((state == IDLE) && conv_start) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            sel_q     <= mux_sel;
        end else if ((state == CAPTURE) && strb_a && (mux_sel == sel_q)) begin
            shift_reg <= {shift_reg[NBITS-2:0], comp_s};
            bit_cnt   <= bit_cnt + 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign word_valid = (fcnt != '0);
    assign fifo_full  = (fcnt == FULL_CNT);
    assign pop        = word_valid && word_ready;
    assign push       = (state == PUSH) && (!fifo_full || pop);
    assign drop       = (state == PUSH) && fifo_full && !pop;

    // FIFO storage; a push into a full FIFO with a pop reuses the slot being vacated.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sel_q, shift_reg};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fcnt <= fcnt + 1'b1;
            end else if (pop && !push) begin
                fcnt <= fcnt - 1'b1;
            end
        end
    end

    // Head is gated so outputs read zero whenever the FIFO is empty.
    assign head      = mem[rd_ptr];
    assign word_data = word_valid ? head[NBITS-1:0] : '0;
    assign word_sel  = word_valid ? head[EW-1:NBITS] : '0;

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_comp_capture.sv
module tb_comp_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        comp_out;
    logic [3:0]  mux_sel;
    logic        conv_start;
    logic        bit_strobe;
    logic [15:0] word_data;
    logic [3:0]  word_sel;
    logic        word_valid;
    logic        word_ready;
    logic        busy;
    logic        overflow;
    logic        ovf_clr;
    wire         vdd_d = 1'b1;
    wire         vss_d = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    comp_capture #(
        .NBITS      (16),
        .FIFO_DEPTH (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .comp_out  (comp_out),
        .mux_sel   (mux_sel),
        .conv_start(conv_start),
        .bit_strobe(bit_strobe),
        .word_data (word_data),
        .word_sel  (word_sel),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy      (busy),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .vdd_d     (vdd_d),
        .vss_d     (vss_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [3:0] s);
        mux_sel    = s;
        conv_start = 1'b1;
        tick(1);
        conv_start = 1'b0;
    endtask

    // Sends the first n bits of w MSB first; restart_at >= 0 also pulses conv_start with that strobe.
    task automatic send_bits(input logic [15:0] w, input int n, input int restart_at);
        for (int i = 0; i < n; i++) begin
            comp_out   = w[15-i];
            bit_strobe = 1'b1;
            conv_start = (i == restart_at);
            tick(1);
            bit_strobe = 1'b0;
            conv_start = 1'b0;
            tick(1);
        end
    endtask

    task automatic conv(input logic [15:0] w, input logic [3:0] s);
        start(s);
        send_bits(w, 16, -1);
        tick(2);
    endtask

    initial begin
        rst_n      = 1'b0;
        comp_out   = 1'b0;
        mux_sel    = 4'd0;
        conv_start = 1'b0;
        bit_strobe = 1'b0;
        word_ready = 1'b0;
        ovf_clr    = 1'b0;
        tick(2);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_data", 32'(word_data), 32'd0);
        check("rst_sel", 32'(word_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single conversion with latency check.
        start(4'd5);
        send_bits(16'hA0F3, 16, -1);
        check("t1_valid_early", 32'(word_valid), 32'd0);
        tick(1);
        check("t1_busy_push", 32'(busy), 32'd1);
        check("t1_valid_push", 32'(word_valid), 32'd0);
        tick(1);
        check("t1_valid", 32'(word_valid), 32'd1);
        check("t1_data", 32'(word_data), 32'hA0F3);
        check("t1_sel", 32'(word_sel), 32'd5);
        check("t1_busy_idle", 32'(busy), 32'd0);
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
        check("t1_drained", 32'(word_valid), 32'd0);

        // Fill with backpressure, fifth word dropped.
        for (int k = 1; k <= 5; k++) begin
            conv(16'(k), 4'd4);
        end
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_head", 32'(word_data), 32'h0001);
        tick(3);
        check("t2_hold", 32'(word_data), 32'h0001);
        check("t2_hold_sel", 32'(word_sel), 32'd4);
        word_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t2_pop%0d", k), 32'(word_data), 32'(k));
            tick(1);
        end
        word_ready = 1'b0;
        check("t2_empty", 32'(word_valid), 32'd0);
        check("t2_ovf_kept", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with a pop in the PUSH cycle: no drop.
        for (int k = 1; k <= 4; k++) begin
            conv(16'(32'h10 + k), 4'd2);
        end
        check("t3_ovf_fill", 32'(overflow), 32'd0);
        start(4'd2);
        send_bits(16'h0015, 16, -1);
        tick(1);
        check("t3_in_push", 32'(busy), 32'd1);
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
        check("t3_no_ovf", 32'(overflow), 32'd0);
        word_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("t3_pop%0d", k), 32'(word_data), 32'(32'h10 + k));
            tick(1);
        end
        word_ready = 1'b0;
        check("t3_empty", 32'(word_valid), 32'd0);

        // mux_sel change mid-capture aborts.
        start(4'd3);
        send_bits(16'hFFFF, 8, -1);
        mux_sel = 4'd7;
        tick(1);
        check("t4_abort_busy", 32'(busy), 32'd0);
        tick(8);
        check("t4_no_word", 32'(word_valid), 32'd0);
        check("t4_no_ovf", 32'(overflow), 32'd0);
        conv(16'h1234, 4'd7);
        check("t4_data", 32'(word_data), 32'h1234);
        check("t4_sel", 32'(word_sel), 32'd7);
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;

        // Asynchronous reset mid-capture with a word buffered.
        conv(16'hBEEF, 4'd1);
        check("t5_pre_valid", 32'(word_valid), 32'd1);
        start(4'd1);
        send_bits(16'hFFFF, 10, -1);
        check("t5_pre_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(word_valid), 32'd0);
        check("t5_data", 32'(word_data), 32'd0);
        check("t5_sel", 32'(word_sel), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        tick(1);
        rst_n = 1'b1;
        send_bits(16'hFFFF, 6, -1);
        tick(6);
        check("t5_stray_valid", 32'(word_valid), 32'd0);
        check("t5_stray_busy", 32'(busy), 32'd0);

        // Idle strobes and a repeated conv_start are ignored.
        send_bits(16'hFFFF, 3, -1);
        tick(4);
        start(4'd9);
        send_bits(16'hC35A, 16, 5);
        tick(2);
        check("t6_valid", 32'(word_valid), 32'd1);
        check("t6_data", 32'(word_data), 32'hC35A);
        check("t6_sel", 32'(word_sel), 32'd9);
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
        tick(4);
        check("t6_single", 32'(word_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
